uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 98 +++++++++
 tb/tb_uart_rx_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between a UART receiver and its consumer.
// First-word-fall-through, sticky overflow flag, asynchronous active-high reset.
module uart_rx_fifo #(
    parameter int p_WORD_LEN = 8,
    parameter int p_DEPTH    = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [p_WORD_LEN-1:0]          i_data,
    input  logic                           i_ready,
    input  logic                           i_read,
    input  logic                           i_clr_overflow,
    output logic [p_WORD_LEN-1:0]          o_data,
    output logic                           o_valid,
    output logic [$clog2(p_DEPTH+1)-1:0]   o_count,
    output logic                           o_full,
    output logic                           o_empty,
    output logic                           o_overflow
);

    localparam int c_AW = $clog2(p_DEPTH);
    localparam int c_CW = $clog2(p_DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(p_DEPTH);

    generate
        if (p_DEPTH < 2 || (p_DEPTH & (p_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_rx_fifo: p_DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [p_WORD_LEN-1:0] mem [p_DEPTH];
    logic [c_AW-1:0]       wr_ptr;
    logic [c_AW-1:0]       rd_ptr;
    logic [c_CW-1:0]       count;
    logic                  overflow;

    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // Handshake: a word is written when i_ready is high and there is room
    // (or a pop frees a slot in the same cycle); a word leaves when i_read
    // and o_valid are both high at a rising edge. i_read with o_valid low
    // is ignored. A write strobe that finds no room is a drop.
    always_comb begin
        full  = (count == c_FULL);
        empty = (count == '0);
        pop   = i_read && !empty;
        push  = i_ready && (!full || pop);
        drop  = i_ready && full && !pop;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + c_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + c_AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + c_CW'(1);
                2'b01:   count <= count - c_CW'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is not reset; its contents are masked by o_valid.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_comb begin
        o_valid    = !empty;
        o_empty    = empty;
        o_full     = full;
        o_count    = count;
        o_overflow = overflow;
        o_data     = empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed stimulus, expected words queued by the driver
// and checked by a negedge monitor on every accepted read.
module tb_uart_rx_fifo;

    localparam int W = 8;
    localparam int D = 16;
    localparam int CW = $clog2(D + 1);

    logic          i_clk;
    logic          i_rst;
    logic [W-1:0]  i_data;
    logic          i_ready;
    logic          i_read;
    logic          i_clr_overflow;
    logic [W-1:0]  o_data;
    logic          o_valid;
    logic [CW-1:0] o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_overflow;

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int max_count;

    uart_rx_fifo #(.p_WORD_LEN(W), .p_DEPTH(D)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_data         (i_data),
        .i_ready        (i_ready),
        .i_read         (i_read),
        .i_clr_overflow (i_clr_overflow),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_count        (o_count),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_overflow     (o_overflow)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // scoreboard monitor: a read is accepted at the coming edge
    always @(negedge i_clk) begin
        if (!i_rst && i_read && o_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL read_unexpected: got %0h, required no word", o_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    n_fail++;
                    $display("FAIL read_data: got %0h, required %0h", o_data, e);
                end
            end
        end
    end

    // driver tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic cyc(input logic rdy, input logic [W-1:0] d, input logic rd, input logic clr);
        i_ready        = rdy;
        i_data         = d;
        i_read         = rd;
        i_clr_overflow = clr;
        @(posedge i_clk);
        #1;
        i_ready        = 1'b0;
        i_data         = '0;
        i_read         = 1'b0;
        i_clr_overflow = 1'b0;
    endtask

    task automatic push_word(input logic [W-1:0] d);
        exp_q.push_back(d);
        cyc(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic read_word();
        cyc(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},    32'(o_valid),    32'd0);
        check({tag, "_empty"},    32'(o_empty),    32'd1);
        check({tag, "_full"},     32'(o_full),     32'd0);
        check({tag, "_count"},    32'(o_count),    32'd0);
        check({tag, "_overflow"}, 32'(o_overflow), 32'd0);
        check({tag, "_data"},     32'(o_data),     32'd0);
    endtask

    initial begin
        i_rst = 1'b1;
        i_ready = 1'b0;
        i_data = '0;
        i_read = 1'b0;
        i_clr_overflow = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_reset_outputs("reset");
        i_rst = 1'b0;

        // single word
        push_word(8'hA5);
        check("single_valid", 32'(o_valid), 32'd1);
        check("single_data",  32'(o_data),  32'hA5);
        check("single_count", 32'(o_count), 32'd1);
        read_word();
        check("single_valid_after", 32'(o_valid), 32'd0);
        check("single_data_after",  32'(o_data),  32'h00);
        check("single_count_after", 32'(o_count), 32'd0);
        read_word();
        check("empty_read_count", 32'(o_count), 32'd0);
        check("empty_read_empty", 32'(o_empty), 32'd1);

        // fill, drop one, drain
        for (int i = 0; i < D; i++) push_word(W'(i));
        check("fill_full",  32'(o_full),  32'd1);
        check("fill_count", 32'(o_count), 32'd16);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        check("drop_overflow", 32'(o_overflow), 32'd1);
        check("drop_count",    32'(o_count),    32'd16);
        for (int i = 0; i < D; i++) read_word();
        check("drain_empty",       32'(o_empty),    32'd1);
        check("drain_overflow_sticky", 32'(o_overflow), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("clr_overflow", 32'(o_overflow), 32'd0);

        // full with simultaneous push and pop
        for (int i = 0; i < D; i++) push_word(W'(8'h10 + i));
        exp_q.push_back(8'h55);
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        check("fullpp_count",    32'(o_count),    32'd16);
        check("fullpp_overflow", 32'(o_overflow), 32'd0);
        check("fullpp_full",     32'(o_full),     32'd1);
        for (int i = 0; i < D; i++) read_word();
        check("fullpp_drained", 32'(o_count), 32'd0);

        // empty with simultaneous push and read
        exp_q.push_back(8'h77);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        check("emptypp_count", 32'(o_count), 32'd1);
        check("emptypp_data",  32'(o_data),  32'h77);
        read_word();

        // wrap-around: each word read two cycles after its push
        max_count = 0;
        for (int k = 0; k < 42; k++) begin
            if (k < 40) exp_q.push_back(W'(k));
            cyc(k < 40, W'(k), k >= 2, 1'b0);
            if (int'(o_count) > max_count) max_count = int'(o_count);
        end
        check("wrap_max_count", 32'(max_count), 32'd2);
        check("wrap_end_count", 32'(o_count),   32'd0);

        // drop coinciding with overflow clear
        for (int i = 0; i < D; i++) push_word(W'(8'h80 + i));
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        check("race_overflow_set", 32'(o_overflow), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("race_overflow_clr", 32'(o_overflow), 32'd0);
        for (int i = 0; i < D - 5; i++) read_word();
        check("pre_reset_count", 32'(o_count), 32'd5);

        // asynchronous reset between edges with five words stored
        #2;
        i_rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        i_data  = 8'h99;
        i_read  = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        i_read  = 1'b0;
        check("rst_ignores_push", 32'(o_count), 32'd0);
        i_rst = 1'b0;
        push_word(8'h3C);
        check("post_rst_data",  32'(o_data),  32'h3C);
        check("post_rst_count", 32'(o_count), 32'd1);
        read_word();
        check("post_rst_empty", 32'(o_empty), 32'd1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
